mem_port_ctrl: RTL and testbench

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

---
 rtl/mem_port_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_port_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// Single-outstanding load/store port between a core and a byte-addressed RAM.
// Optional macro MEM_ALIGN_CHECK_EN rejects accesses not aligned to their size.
module mem_port_ctrl #(
    parameter int unsigned RAM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_width,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [63:0] ram_addr,
    output logic [63:0] ram_wdata,
    output logic [1:0]  ram_width,
    input  logic [63:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    localparam logic [63:0] RAM_LIMIT = 64'(RAM_BYTES);

    function automatic logic [3:0] acc_size(input logic [1:0] w);
        case (w)
            2'd0:    return 4'd8;
            2'd1:    return 4'd4;
            2'd2:    return 4'd2;
            default: return 4'd1;
        endcase
    endfunction

    // Distance between the right-justified and left-justified positions of the data.
    function automatic logic [5:0] lj_shift(input logic [1:0] w);
        case (w)
            2'd0:    return 6'd0;
            2'd1:    return 6'd32;
            2'd2:    return 6'd48;
            default: return 6'd56;
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                                input logic [1:0]  w,
                                                input logic        sgn);
        logic [63:0] rj;
        logic [63:0] ext;
        rj = rdata >> lj_shift(w);
        case (w)
            2'd0:    ext = rj;
            2'd1:    ext = {{32{sgn & rj[31]}}, rj[31:0]};
            2'd2:    ext = {{48{sgn & rj[15]}}, rj[15:0]};
            default: ext = {{56{sgn & rj[7]}},  rj[7:0]};
        endcase
        return ext;
    endfunction

    state_t      state, state_n;
    logic [3:0]  size;
    logic [63:0] size64;
    logic        in_range;
    logic        misalign;
    logic        reject;
    logic        accept;
    logic [1:0]  width_p0;
    logic        sgn_p0;
    logic [63:0] resp_data_p1;
    logic        resp_err_p1;

    assign size   = acc_size(req_width);
    assign size64 = {60'd0, size};

    // Subtracting from the limit (only once addr is below it) avoids addr+S wrapping.
    assign in_range = (req_addr < RAM_LIMIT) && (size64 <= (RAM_LIMIT - req_addr));

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (req_addr[2:0] & (size[2:0] - 3'd1)) != 3'd0;
`else
    assign misalign = 1'b0;
`endif

    assign reject    = !in_range || misalign;
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    assign ram_addr   = req_addr;
    assign ram_width  = req_width;
    assign ram_wdata  = req_wdata << lj_shift(req_width);
    assign resp_valid = (state == RESP);
    assign resp_data  = resp_data_p1;
    assign resp_err   = resp_err_p1;

    always_comb begin
        state_n = state;
        ram_cs  = 1'b0;
        ram_we  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        state_n = RESP;
                    end else begin
                        ram_cs  = 1'b1;
                        ram_we  = req_we;
                        state_n = req_we ? RESP : RD_WAIT;
                    end
                end
            end
            RD_WAIT: state_n = RESP;
            RESP:    if (resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // p0: load format captured at accept
    always_ff @(posedge clk) begin
        if (accept) begin
            width_p0 <= req_width;
            sgn_p0   <= req_signed;
        end
    end

    // p1: response registers, held through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data_p1 <= '0;
            resp_err_p1  <= 1'b0;
        end else if (accept) begin
            resp_data_p1 <= '0;
            resp_err_p1  <= reject;
        end else if (state == RD_WAIT) begin
            resp_data_p1 <= load_extend(ram_rdata, width_p0, sgn_p0);
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl: directed stores/loads against a byte RAM model.
module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [1:0]  req_width;
    logic        req_signed;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        ram_cs;
    logic        ram_we;
    logic [63:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [1:0]  ram_width;
    logic [63:0] ram_rdata;

    mem_port_ctrl #(.RAM_BYTES(65536)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_width(req_width), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_width(ram_width), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          vcyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   pass_cnt = 0;
    int   cyc = 0;
    int   cs_count = 0;
    bit   seen = 0;
    logic [7:0] mem [0:65535];

    function automatic int tb_size(input logic [1:0] w);
        return (w == 2'd0) ? 8 : (w == 2'd1) ? 4 : (w == 2'd2) ? 2 : 1;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_cs) cs_count <= cs_count + 1;
    end

    // Byte RAM: registered, left-justified read data
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int i = 0; i < 8; i++)
                    if (i < tb_size(ram_width))
                        mem[16'(ram_addr + 64'(i))] <= ram_wdata[63-8*i -: 8];
            end else begin
                for (int i = 0; i < 8; i++)
                    ram_rdata[63-8*i -: 8] <= mem[16'(ram_addr + 64'(i))];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    // Monitor: checks latency on first sight, stability while stalled, data at handshake.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_resp: got resp_valid=1 data %h expected no response", resp_data);
            end else begin
                if (!seen) begin
                    chk("resp_latency", 64'(cyc), 64'(sb[0].vcyc));
                    seen = 1;
                end
                if (resp_ready) begin
                    chk("resp_data", resp_data, sb[0].data);
                    chk("resp_err", 64'(resp_err), 64'(sb[0].err));
                    void'(sb.pop_front());
                    seen = 0;
                end else begin
                    chk("stall_data", resp_data, sb[0].data);
                    chk("stall_req_ready", 64'(req_ready), 64'd0);
                end
            end
        end
    end

    task automatic do_req(input string name, input logic we, input logic [63:0] addr,
                          input logic [1:0] w, input logic sgn, input logic [63:0] wdata,
                          input logic [63:0] exp_lj, input logic [63:0] exp_data,
                          input logic exp_err, input bit push, output int waits);
        exp_t e;
        bit   got;
        req_we = we; req_addr = addr; req_width = w; req_signed = sgn; req_wdata = wdata;
        req_valid = 1'b1;
        waits = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1;
                chk({name, "_cs"}, 64'(ram_cs), 64'(!exp_err));
                if (!exp_err) begin
                    chk({name, "_we"}, 64'(ram_we), 64'(we));
                    chk({name, "_addr"}, ram_addr, addr);
                    chk({name, "_width"}, 64'(ram_width), 64'(w));
                    if (we) chk({name, "_wdata"}, ram_wdata, exp_lj);
                end
                e.data = exp_data;
                e.err  = exp_err;
                e.vcyc = cyc + 1 + ((!we && !exp_err) ? 1 : 0);
                if (push) sb.push_back(e);
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!got) begin
            total++;
            $display("FAIL %s_accept: got no accept expected accept within 20 cycles", name);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
            sb.delete();
            seen = 0;
        end
    endtask

    task automatic txn(input string name, input logic we, input logic [63:0] addr,
                       input logic [1:0] w, input logic sgn, input logic [63:0] wdata,
                       input logic [63:0] exp_lj, input logic [63:0] exp_data,
                       input logic exp_err, output int waits);
        int cs0;
        cs0 = cs_count;
        do_req(name, we, addr, w, sgn, wdata, exp_lj, exp_data, exp_err, 1'b1, waits);
        drain();
        chk({name, "_cs_cycles"}, 64'(cs_count - cs0), exp_err ? 64'd0 : 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cs0;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_width = '0;
        req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b1; req_addr = 64'h10;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_ram_cs", 64'(ram_cs), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        txn("st64", 1, 64'h10, 2'd0, 0, 64'h1122334455667788, 64'h1122334455667788, 64'd0, 0, w);
        chk("first_accept_waits", 64'(w), 64'd0);
        txn("ld64", 0, 64'h10, 2'd0, 0, 64'd0, 64'd0, 64'h1122334455667788, 0, w);
        txn("st8", 1, 64'h23, 2'd3, 0, 64'h80, 64'h8000000000000000, 64'd0, 0, w);
        txn("ld8s", 0, 64'h23, 2'd3, 1, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFF80, 0, w);
        txn("ld8u", 0, 64'h23, 2'd3, 0, 64'd0, 64'd0, 64'h80, 0, w);
        txn("st32", 1, 64'h40, 2'd1, 0, 64'hDEADBEEF, 64'hDEADBEEF00000000, 64'd0, 0, w);
        txn("ld32s", 0, 64'h40, 2'd1, 1, 64'd0, 64'd0, 64'hFFFFFFFFDEADBEEF, 0, w);
        txn("ld16u", 0, 64'h40, 2'd2, 0, 64'd0, 64'd0, 64'hDEAD, 0, w);
        txn("st16", 1, 64'h50, 2'd2, 0, 64'hFFFFFFFFFFFF1234, 64'h1234000000000000, 64'd0, 0, w);
        txn("ld16s", 0, 64'h50, 2'd2, 1, 64'd0, 64'd0, 64'h1234, 0, w);
        txn("st32_top", 1, 64'hFFFC, 2'd1, 0, 64'hCAFEF00D, 64'hCAFEF00D00000000, 64'd0, 0, w);
        txn("ld32_top", 0, 64'hFFFC, 2'd1, 0, 64'd0, 64'd0, 64'hCAFEF00D, 0, w);
        txn("st8_last", 1, 64'hFFFF, 2'd3, 0, 64'h5A, 64'h5A00000000000000, 64'd0, 0, w);
        txn("ld32_oor", 0, 64'hFFFE, 2'd1, 1, 64'd0, 64'd0, 64'd0, 1, w);
        txn("ld8_oor", 0, 64'h10000, 2'd3, 0, 64'd0, 64'd0, 64'd0, 1, w);
        txn("ld64_wrap", 0, 64'hFFFFFFFFFFFFFFF8, 2'd0, 0, 64'd0, 64'd0, 64'd0, 1, w);
        txn("st64_oor", 1, 64'hFFF9, 2'd0, 0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0, 1, w);
`ifdef MEM_ALIGN_CHECK_EN
        txn("ld16_unal", 0, 64'h11, 2'd2, 0, 64'd0, 64'd0, 64'd0, 1, w);
`else
        txn("ld16_unal", 0, 64'h11, 2'd2, 0, 64'd0, 64'd0, 64'h2233, 0, w);
`endif

        // Response stall with a competing request that must be ignored
        resp_ready = 1'b0;
        cs0 = cs_count;
        do_req("ld64_stall", 0, 64'h10, 2'd0, 0, 64'd0, 64'd0, 64'h1122334455667788, 0, 1'b1, w);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h30; req_width = 2'd0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("stall_cs_cycles", 64'(cs_count - cs0), 64'd1);
        resp_ready = 1'b1;
        drain();

        // Reset while the load is in RD_WAIT discards it
        do_req("ld64_rst", 0, 64'h10, 2'd0, 0, 64'd0, 64'd0, 64'd0, 0, 1'b0, w);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rdwait_rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rdwait_rst_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        txn("ld8u_post_rst", 0, 64'h23, 2'd3, 0, 64'd0, 64'd0, 64'h80, 0, w);
        chk("post_rst_accept_waits", 64'(w), 64'd0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
